// File: rtl/divider_seq.sv
// Sequential restoring divider with RISC-V DIV/DIVU/REM/REMU result semantics.
// Signed operation is compiled in only when DIV_SIGNED_EN is defined.
module divider_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t state, state_nx;

    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] d;
    logic [CW-1:0]    cnt;
    logic             dz;
    logic [WIDTH:0]   t;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH-1:0] q_res, r_res;

`ifdef DIV_SIGNED_EN
    logic neg_a, neg_b;
    logic qs, rs;

    assign neg_a = op_signed & dividend[WIDTH-1];
    assign neg_b = op_signed & divisor[WIDTH-1];
    assign a_mag = neg_a ? -dividend : dividend;
    assign b_mag = neg_b ? -divisor : divisor;
    assign q_res = qs ? -q : q;
    assign r_res = rs ? -r : r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qs <= 1'b0;
            rs <= 1'b0;
        end else if (state == IDLE && start) begin
            qs <= neg_a ^ neg_b;
            rs <= neg_a;
        end
    end
`else
    logic unused_op_signed;

    assign unused_op_signed = op_signed;
    assign a_mag = dividend;
    assign b_mag = divisor;
    assign q_res = q;
    assign r_res = r;
`endif

    // trial subtract of the shifted partial remainder; t[WIDTH] is the borrow
    assign t = {r, q[WIDTH-1]} - {1'b0, d};

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (start) state_nx = (divisor == '0) ? FIX : CALC;
            CALC: if (cnt == '0) state_nx = FIX;
            FIX:  state_nx = DONE;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r         <= '0;
            q         <= '0;
            d         <= '0;
            cnt       <= '0;
            dz        <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (start) begin
                    // keep the raw dividend on divide-by-zero: it is the remainder
                    q   <= (divisor == '0) ? dividend : a_mag;
                    d   <= b_mag;
                    r   <= '0;
                    cnt <= CW'(WIDTH - 1);
                    dz  <= (divisor == '0);
                end
                CALC: begin
                    if (!t[WIDTH]) begin
                        r <= t[WIDTH-1:0];
                        q <= {q[WIDTH-2:0], 1'b1};
                    end else begin
                        r <= {r[WIDTH-2:0], q[WIDTH-1]};
                        q <= {q[WIDTH-2:0], 1'b0};
                    end
                    cnt <= cnt - 1'b1;
                end
                FIX: begin
                    if (dz) begin
                        quotient  <= '1;
                        remainder <= q;
                        div_zero  <= 1'b1;
                    end else begin
                        quotient  <= q_res;
                        remainder <= r_res;
                        div_zero  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_divider_seq.sv
// Scoreboard bench for divider_seq: random and directed operations checked
// against a plain-arithmetic model of the RISC-V divide results.
module tb_divider_seq;

    localparam int W = 32;

`ifdef DIV_SIGNED_EN
    localparam bit SGN = 1'b1;
`else
    localparam bit SGN = 1'b0;
`endif

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        int           lat;
        int           acc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         op_signed = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy, done, div_zero;
    logic [W-1:0] quotient, remainder;

    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   n_done = 0;
    exp_t sb[$];

    divider_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op_signed(op_signed),
        .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
        .quotient(quotient), .remainder(remainder), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input bit s, input logic [W-1:0] a,
                                   input logic [W-1:0] b);
        exp_t e;
        longint sa, sb_;
        e.acc = 0;
        if (b == '0) begin
            e.q = '1; e.r = a; e.dz = 1'b1; e.lat = 2;
        end else begin
            e.dz = 1'b0; e.lat = W + 2;
            if (s && SGN) begin
                sa = longint'($signed(a));
                sb_ = longint'($signed(b));
                e.q = W'(sa / sb_);
                e.r = W'(sa % sb_);
            end else begin
                e.q = a / b;
                e.r = a % b;
            end
        end
        return e;
    endfunction

    // monitor: every done pulse must match the oldest outstanding operation
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done) begin
            n_done++;
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("quotient", quotient, e.q);
                chk("remainder", remainder, e.r);
                chk("div_zero", div_zero, e.dz);
                chk("latency", cyc - e.acc + 1, e.lat);
                chk("busy_in_done", busy, 1);
            end
        end
    end

    task automatic wait_idle();
        int g = 0;
        @(negedge clk);
        while (busy && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (busy) chk("idle_timeout", 1, 0);
    endtask

    task automatic issue(input bit s, input logic [W-1:0] a,
                         input logic [W-1:0] b, input bit hold);
        exp_t e;
        wait_idle();
        op_signed = s;
        dividend  = a;
        divisor   = b;
        start     = 1'b1;
        @(posedge clk);
        #1;
        e = model(s, a, b);
        e.acc = cyc;
        sb.push_back(e);
        if (!hold) start = 1'b0;
    endtask

    initial begin
        int acc_a, g, d0;
        logic [W-1:0] a, b;

        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_quotient", quotient, 0);
        chk("rst_remainder", remainder, 0);
        chk("rst_div_zero", div_zero, 0);
        @(negedge clk);
        rst_n = 1'b1;

        issue(0, 100, 7, 0);
        issue(1, -32'sd7, 2, 0);
        issue(1, 7, -32'sd2, 0);
        issue(0, 32'h1234_5678, 0, 0);
        issue(1, 32'h1234_5678, 0, 0);
        issue(1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        issue(0, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        issue(0, 32'hFFFF_FFFF, 1, 0);
        issue(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);

        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            b = $urandom;
            if (i % 3 == 0) b = W'($urandom_range(1, 20));
            if (i % 8 == 5) b = '0;
            issue(1'($urandom_range(0, 1)), a, b, 0);
        end

        // start held high through an operation: only the IDLE cycle accepts
        issue(0, 1000, 33, 1);
        acc_a = cyc;
        g = 0;
        while (g < 100) begin
            @(negedge clk);
            if (!busy) break;
            dividend = $urandom;
            divisor  = $urandom;
            g++;
        end
        begin
            exp_t e;
            op_signed = 1'b0;
            dividend  = 5000;
            divisor   = 9;
            @(posedge clk);
            #1;
            e = model(0, 5000, 9);
            e.acc = cyc;
            sb.push_back(e);
            chk("hold_accept_gap", cyc - acc_a, W + 3);
            start = 1'b0;
        end

        // reset in the middle of CALC
        issue(0, 32'hDEAD_BEEF, 3, 0);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_quotient", quotient, 0);
        chk("midrst_remainder", remainder, 0);
        chk("midrst_div_zero", div_zero, 0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        d0 = n_done;
        repeat (45) @(negedge clk);
        chk("no_done_after_rst", n_done - d0, 0);
        issue(0, 32'hDEAD_BEEF, 3, 0);

        g = 0;
        while (sb.size() != 0 && g < 200) begin
            @(negedge clk);
            g++;
        end
        chk("drain_timeout", sb.size(), 0);
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
